// File: rtl/sel_dff_pipe.sv
// sel_dff_pipe: WIDTH-bit, DEPTH-stage delay/invert line with per-stage valid bits and a fill count.
// Define SEL_DFF_PIPE_PARITY_EN to carry a parity bit per stage and drive q_par_err.
module sel_dff_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CNT_W-1:0] fill,
    output logic             q_par_err
);

    // in_valid qualifies d/sel only on edges where en=1 and flush=0; there is no
    // backpressure, so a beat offered while en=0 or flush=1 is simply dropped.
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CNT_W-1:0] r_fill;

    logic [WIDTH-1:0] w_stage0;
    logic [CNT_W-1:0] w_fill_in;
    logic [CNT_W-1:0] w_fill_out;

    assign w_stage0   = sel ? ~d : d;
    assign w_fill_in  = CNT_W'(in_valid);
    assign w_fill_out = CNT_W'(r_valid[DEPTH-1]);

    // Flush clears only the valid bits; stage data keeps whatever it held.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
            r_fill  <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_fill  <= '0;
        end else if (en) begin
            r_data[0]  <= w_stage0;
            r_valid[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
            end
            r_fill <= r_fill + w_fill_in - w_fill_out;
        end
    end

    assign q       = r_data[DEPTH-1];
    assign q_valid = r_valid[DEPTH-1];
    assign fill    = r_fill;

`ifdef SEL_DFF_PIPE_PARITY_EN
    logic [DEPTH-1:0] r_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= '0;
        end else if (!flush && en) begin
            r_par[0] <= ^w_stage0;
            for (int i = 1; i < DEPTH; i++) begin
                r_par[i] <= r_par[i-1];
            end
        end
    end

    assign q_par_err = r_valid[DEPTH-1] & ((^r_data[DEPTH-1]) != r_par[DEPTH-1]);
`else
    assign q_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sel_dff_pipe.sv
// Testbench for sel_dff_pipe (WIDTH=8, DEPTH=3): queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_sel_dff_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef SEL_DFF_PIPE_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             sel = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CNT_W-1:0] fill;
    logic             q_par_err;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    // Reference pipeline: index 0 is the newest entry, index DEPTH-1 is what q shows.
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_v[$];
    logic             exp_c[$];

    sel_dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .d         (d),
        .sel       (sel),
        .in_valid  (in_valid),
        .q         (q),
        .q_valid   (q_valid),
        .fill      (fill),
        .q_par_err (q_par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic t_rst, input logic t_en, input logic t_flush,
                        input logic t_sel, input logic t_iv, input logic [WIDTH-1:0] t_d);
        rst      = t_rst;
        en       = t_en;
        flush    = t_flush;
        sel      = t_sel;
        in_valid = t_iv;
        d        = t_d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_v.delete();
        exp_c.delete();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back('0);
            exp_v.push_back(1'b0);
            exp_c.push_back(1'b0);
        end
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else if (flush) begin
            foreach (exp_v[i]) exp_v[i] = 1'b0;
        end else if (en) begin
            exp_q.push_front(sel ? ~d : d);
            exp_v.push_front(in_valid);
            exp_c.push_front(1'b0);
            void'(exp_q.pop_back());
            void'(exp_v.pop_back());
            void'(exp_c.pop_back());
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            int cnt;
            cnt = 0;
            foreach (exp_v[i]) cnt += int'(exp_v[i]);
            check("q_valid", 32'(q_valid), 32'(exp_v[DEPTH-1]));
            check("fill", 32'(fill), 32'(cnt));
            check("q_par_err", 32'(q_par_err), 32'(PAR & exp_v[DEPTH-1] & exp_c[DEPTH-1]));
            if (exp_v[DEPTH-1]) check("q", 32'(q), 32'(exp_q[DEPTH-1]));
        end
    end

    initial begin
        // Reset with en/in_valid asserted: inputs must be ignored.
        step(1, 1, 0, 0, 1, 8'hFF);
        cmp_on = 1'b1;
        step(1, 1, 0, 0, 1, 8'hFF);
        check("rst_q", 32'(q), 32'h00);
        check("rst_q_valid", 32'(q_valid), 32'h0);
        check("rst_fill", 32'(fill), 32'h0);
        step(0, 0, 0, 0, 1, 8'hFF);
        step(0, 0, 0, 0, 1, 8'hFF);
        check("post_rst_hold_fill", 32'(fill), 32'h0);
        check("post_rst_hold_q_valid", 32'(q_valid), 32'h0);

        // Straight-through beats, fill counts up.
        step(0, 1, 0, 0, 1, 8'hA5);
        check("fill_1", 32'(fill), 32'h1);
        step(0, 1, 0, 0, 1, 8'h3C);
        check("fill_2", 32'(fill), 32'h2);
        step(0, 1, 0, 0, 1, 8'h01);
        check("fill_3", 32'(fill), 32'h3);
        check("lat_q_A5", 32'(q), 32'hA5);
        check("lat_q_valid", 32'(q_valid), 32'h1);
        step(0, 1, 0, 0, 0, 8'h00);
        check("q_3C", 32'(q), 32'h3C);
        step(0, 1, 0, 0, 0, 8'h00);
        check("q_01", 32'(q), 32'h01);
        step(0, 1, 0, 0, 0, 8'h00);
        check("drain_q_valid", 32'(q_valid), 32'h0);

        // Inversion applies only to the beat captured with sel=1.
        step(0, 1, 0, 1, 1, 8'hA5);
        step(0, 1, 0, 0, 1, 8'hA5);
        step(0, 1, 0, 0, 0, 8'h00);
        check("inv_q_5A", 32'(q), 32'h5A);
        step(0, 1, 0, 0, 0, 8'h00);
        check("noinv_q_A5", 32'(q), 32'hA5);
        step(0, 1, 0, 0, 0, 8'h00);

        // Hold while en=0, then drain with invalid beats.
        step(0, 1, 0, 0, 1, 8'h11);
        step(0, 1, 0, 0, 1, 8'h22);
        step(0, 1, 0, 0, 1, 8'h33);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, i[0], ~i[0], WIDTH'($urandom_range(0, 255)));
        end
        check("hold_q", 32'(q), 32'h11);
        check("hold_fill", 32'(fill), 32'h3);
        step(0, 1, 0, 0, 0, 8'h00);
        check("dec_fill_2", 32'(fill), 32'h2);
        check("dec_q_22", 32'(q), 32'h22);
        step(0, 1, 0, 0, 0, 8'h00);
        check("dec_fill_1", 32'(fill), 32'h1);
        step(0, 1, 0, 0, 0, 8'h00);
        check("dec_fill_0", 32'(fill), 32'h0);

        // Flush beats en; the beat offered that cycle is lost.
        step(0, 1, 0, 0, 1, 8'h44);
        step(0, 1, 0, 0, 1, 8'h55);
        step(0, 1, 1, 0, 1, 8'h77);
        check("flush_fill", 32'(fill), 32'h0);
        check("flush_q_valid", 32'(q_valid), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 8'h00);
        check("flush_beat_gone", 32'(q_valid), 32'h0);

        // Reset mid-stream with a full pipe.
        step(0, 1, 0, 0, 1, 8'h66);
        step(0, 1, 0, 0, 1, 8'h77);
        step(0, 1, 0, 0, 1, 8'h88);
        check("full_fill", 32'(fill), 32'h3);
        check("full_q", 32'(q), 32'h66);
        step(1, 1, 1, 0, 1, 8'hFF);
        check("mid_rst_q", 32'(q), 32'h00);
        check("mid_rst_q_valid", 32'(q_valid), 32'h0);
        check("mid_rst_fill", 32'(fill), 32'h0);

        // Parity error detection on a corrupted stage.
        step(0, 1, 0, 0, 1, 8'hAA);
        step(0, 1, 0, 0, 1, 8'hBB);
`ifdef SEL_DFF_PIPE_PARITY_EN
        dut.r_data[1][0] = ~dut.r_data[1][0];
        exp_q[1][0] = ~exp_q[1][0];
        exp_c[1] = 1'b1;
        step(0, 1, 0, 0, 1, 8'hCC);
        check("par_err_q", 32'(q), 32'hAB);
        check("par_err_flag", 32'(q_par_err), 32'h1);
`else
        step(0, 1, 0, 0, 1, 8'hCC);
        check("par_q", 32'(q), 32'hAA);
        check("par_err_off", 32'(q_par_err), 32'h0);
`endif
        step(0, 1, 0, 0, 1, 8'hDD);
        check("par_clean_flag", 32'(q_par_err), 32'h0);

        // Mixed stimulus checked by the reference model only.
        for (int i = 0; i < 40; i++) begin
            step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 255)));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sel_dff_pipe.md
Name: sel_dff_pipe

Overview:
- Parametrised successor to the single-bit select flip-flop.
- A WIDTH-bit, DEPTH-stage register pipeline.
- Stage 0 captures either d or ~d, chosen per cycle by sel. Each stage carries a valid bit. The pipeline also provides an advance enable, a flush and an occupancy count.
- Sits between the stimulus clocking block and downstream checkers as a configurable delay/invert line.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages; equals latency in enabled cycles (>=1).
- CNT_W, $clog2(DEPTH+1), width of fill counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  advance pipeline this cycle
- flush  input  1  synchronous clear of all valid bits
- d  input  WIDTH  data in
- sel  input  1  0: stage0 loads d; 1: stage0 loads ~d
- in_valid  input  1  qualifies d/sel
- q  output  WIDTH  data of last stage (stage DEPTH-1)
- q_valid  output  1  valid of last stage
- fill  output  CNT_W  count of stages whose valid bit is set
- q_par_err  output  1  parity mismatch flag (see Optional Feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port rst.
- Priority per rising clk edge: rst > flush > en > hold.
- rst=1:
  - All stage data = 0, all valid = 0.
  - Outputs after the edge: q=0, q_valid=0, fill=0, q_par_err=0.
  - Inputs are ignored, including en/flush in the same cycle.
  - Reset mid-stream discards all in-flight entries; no partial state survives.
- flush=1 (rst=0):
  - All valid bits = 0, fill = 0.
  - Stage data registers hold their values (not zeroed).
  - en is ignored that cycle; the input beat is dropped.
- en=1 (rst=0, flush=0):
  - stage0.data <= sel ? ~d : d.
  - stage0.valid <= in_valid.
  - stage[i].{data,valid} <= stage[i-1] for i=1..DEPTH-1.
- en=0: all stages hold; d, sel and in_valid are ignored.
- Latency:
  - A beat presented with en=1 at edge k appears on q at edge k+DEPTH-1, provided en stays 1. Visible on q after DEPTH enabled edges in total.
  - DEPTH=1 degenerates to the original single flop with valid and enable.
- Invalid beats (in_valid=0) still shift data; q is don't-care when q_valid=0.
- q and q_valid are registered outputs; there is no combinational path from inputs to outputs.
- fill:
  - Registered.
  - On en=1: fill_next = fill + in_valid − stage[DEPTH-1].valid.
  - Otherwise unchanged (or 0 on rst/flush).
  - Range 0..DEPTH, never wraps.
  - fill==DEPTH only when all stages are valid.
- sel affects only the beat entering that cycle; already-captured data is never re-inverted.
- X on d while in_valid=0 must not propagate into valid or fill.

Optional Feature:
- Macro: SEL_DFF_PIPE_PARITY_EN.
- Defined:
  - Each stage carries an extra parity bit, p0 <= ^(sel ? ~d : d), shifted alongside data under the same rst/flush/en rules. Reset value 0.
  - q_par_err = q_valid & (^q != p_last), combinational from registers.
  - The bench may force a stage bit via hierarchical deposit to exercise the flag.
- Undefined: no parity storage; q_par_err tied to 0. Port list is identical in both builds.

Test Plan (WIDTH=8, DEPTH=3):
1. rst=1 for 2 cycles with en=1, d=8'hFF, in_valid=1 -> q=8'h00, q_valid=0, fill=0; after release with en=0, outputs unchanged.
2. en=1, sel=0, in_valid=1, d=8'hA5 then 8'h3C, 8'h01 -> q=8'hA5 with q_valid=1 after the 3rd edge, then 8'h3C, 8'h01; fill counts 1,2,3.
3. en=1, sel=1, d=8'hA5, in_valid=1 -> q=8'h5A after 3 edges; next beat sel=0, d=8'hA5 -> q=8'hA5.
4. Fill to fill=3, drop en for 5 cycles -> q, q_valid, fill frozen; toggling d/sel has no effect; re-assert en with in_valid=0 -> fill decrements 3,2,1,0.
5. fill=2 with flush=1 and en=1 in the same cycle -> fill=0, q_valid=0; the beat presented that cycle never appears on q. Then rst=1 mid-stream with fill=3 -> all zeros next edge.
6. With SEL_DFF_PIPE_PARITY_EN: deposit a flipped bit in stage1 data -> q_par_err=1 when that beat reaches q with q_valid=1. Without the macro, q_par_err=0 throughout.
